reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Arbitrates write access to the processor's bank of 8-bit enable-gated registers.
- Three requesters share the bank: ALU result, load unit and immediate/move path.
- Picks one write per cycle by round-robin and drives a one-hot register enable plus a shared data bus into the bank.
- Returns a per-requester grant pulse so each source knows its write has landed.

Parameters:
- NUM_REQ, 3: number of write requesters (0 = ALU, 1 = LOAD, 2 = IMM).
- NUM_REGS, 8: number of registers in the bank (≤ 2**ADDR_W).
- DATA_W, 8: register data width.
- ADDR_W, 3: register address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request, level.
- req_addr  input  NUM_REQ*ADDR_W  target register per requester; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  write data per requester; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot, single-cycle grant pulse.
- reg_enable  output  NUM_REGS  one-hot write enable into the register bank.
- reg_data  output  DATA_W  data for the enabled register.
- addr_err  output  1  pulse when a granted address is ≥ NUM_REGS.
- busy  output  1  high in any cycle where a write is being issued.

Behaviour:
- **Clock/reset**
  - Single clock, clk. Reset is synchronous and active-high (rst), sampled on the rising edge.
  - During and after reset: gnt=0, reg_enable=0, reg_data=0, addr_err=0, busy=0. Round-robin pointer = 0, so requester 0 has top priority.
- **Registered outputs**
  - Requests are sampled at edge k.
  - The winner's gnt, reg_enable, reg_data, addr_err and busy are valid for the whole cycle after edge k and clear at edge k+1 unless a new winner exists.
  - Register write therefore occurs at edge k+1. Fixed latency from request sample to bank update: 2 edges.
- **Handshake**
  - A requester holds req, addr and data stable until it sees its gnt high. It may drop or change them in the cycle after gnt.
  - The arbiter ignores req[i] at any edge where gnt[i] is currently high. This prevents a double-write from a held request. Consequence: the same requester can win at most every other cycle.
- **Round-robin arbitration**
  - Search starts at pointer p and proceeds p, p+1, …, wrapping mod NUM_REQ. The first active, unmasked request wins.
  - After a grant to i: p ← (i+1) mod NUM_REQ. With no grant, p is unchanged.
  - Fairness: a held request is granted within NUM_REQ cycles of first being sampled.
- **FSM (2 states)**
  - IDLE: outputs zero; go to WRITE if any eligible request.
  - WRITE: outputs drive the winner. Stay in WRITE if another eligible request exists at the next edge, else return to IDLE.
  - busy = (state == WRITE).
- **Address handling**
  - In-range address a: reg_enable = 1 << a.
  - If a ≥ NUM_REGS: gnt still pulses (request consumed), reg_enable = 0, addr_err = 1 for that cycle.
- **Same-address collisions:** two requests to the same register are serialised by round-robin. The later grant wins the final value; no merging.
- **Reset mid-operation:** rst at an edge during WRITE clears all outputs at that edge. The in-flight write is suppressed and no gnt is issued for any pending request. Requesters still holding req are re-arbitrated from p=0 after reset deasserts.
- **Invariants:** gnt and reg_enable are each at most one-hot. reg_data is 0 whenever busy=0.

Decomposition:
- Shared package proc_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS constants;
  - requester ID constants REQ_ALU=0, REQ_LOAD=1, REQ_IMM=2;
  - state encoding ST_IDLE, ST_WRITE.
- One combinational sub-module, rr_pick.
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner and its index.
  - reg_write_arbiter instantiates it and owns the pointer, the FSM and the output registers.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with req=3'b111 → gnt, reg_enable, reg_data, busy all 0 throughout. First grant after release is gnt=3'b001.
2. Single write: req=3'b010, addr1=5, data1=8'hA5 → next cycle gnt=3'b010, reg_enable=8'b0010_0000, reg_data=8'hA5, busy=1. Following cycle all 0 once req is dropped.
3. Round-robin: req=3'b111 held, addrs 0/1/2, data 11/22/33 → grants 001,010,100,001,… one per cycle. reg_data follows 11,22,33.
4. Back-to-back single requester: req0 held high with data 8'h0F → gnt0 pulses every other cycle, never two consecutive cycles.
5. Bad address: NUM_REGS=6, req2 with addr=7 → gnt=3'b100, reg_enable=0, addr_err=1 for one cycle.
6. Reset mid-write: req=3'b011, assert rst at the edge where gnt0 is high → outputs 0 next cycle. After release, gnt=3'b001 first because the pointer is back at 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants and state encoding for the register-bank write path.
package proc_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  localparam int NUM_REQ  = 3;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_IMM  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [PTR_W-1:0]   win_idx,
  output logic               win_valid
);

  always_comb begin
    win_idx    = '0;
    win_onehot = '0;
    win_valid  = |req;
    // Walk from the farthest offset down so the nearest one to ptr wins.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % NUM_REQ]) begin
        win_idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
      end
    end
    if (win_valid) begin
      win_onehot[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of an enable-gated register bank.
// state    | meaning
// ST_IDLE  | no write issued this cycle, all outputs zero
// ST_WRITE | outputs drive the write chosen at the previous edge
module reg_write_arbiter #(
  parameter int NUM_REQ  = proc_pkg::NUM_REQ,
  parameter int NUM_REGS = proc_pkg::NUM_REGS,
  parameter int DATA_W   = proc_pkg::DATA_W,
  parameter int ADDR_W   = proc_pkg::ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REGS-1:0]         reg_enable,
  output logic [DATA_W-1:0]           reg_data,
  output logic                        addr_err,
  output logic                        busy
);

  import proc_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [PTR_W-1:0]    win_idx;
  logic                win_valid;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_REGS-1:0] win_enable;
  logic                win_bad;

  // A requester whose grant is showing this cycle is still holding req; skip it.
  assign eligible = req & ~gnt;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req        (eligible),
    .ptr        (ptr),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );

  assign win_addr = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_data = req_data[int'(win_idx)*DATA_W +: DATA_W];
  assign win_bad  = int'(win_addr) >= NUM_REGS;

  always_comb begin
    win_enable = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      win_enable[r] = (int'(win_addr) == r);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      gnt        <= '0;
      reg_enable <= '0;
      reg_data   <= '0;
      addr_err   <= 1'b0;
    end else if (win_valid) begin
      state      <= ST_WRITE;
      ptr        <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
      gnt        <= win_onehot;
      reg_enable <= win_enable;
      reg_data   <= win_data;
      addr_err   <= win_bad;
    end else begin
      state      <= ST_IDLE;
      gnt        <= '0;
      reg_enable <= '0;
      reg_data   <= '0;
      addr_err   <= 1'b0;
    end
  end

  assign busy = (state == ST_WRITE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a six-register bank so 6 and 7 are out of range.
module tb_reg_write_arbiter;

  localparam int NREQ  = 3;
  localparam int NREGS = 6;
  localparam int DW    = 8;
  localparam int AW    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [AW-1:0]     a0, a1, a2;
  logic [DW-1:0]     d0, d1, d2;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREGS-1:0]  reg_enable;
  logic [DW-1:0]     reg_data;
  logic              addr_err;
  logic              busy;

  int checks = 0;
  int errors = 0;

  assign req_addr = {a2, a1, a0};
  assign req_data = {d2, d1, d0};

  always #5 clk = ~clk;

  reg_write_arbiter #(
    .NUM_REQ  (NREQ),
    .NUM_REGS (NREGS),
    .DATA_W   (DW),
    .ADDR_W   (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .gnt        (gnt),
    .reg_enable (reg_enable),
    .reg_data   (reg_data),
    .addr_err   (addr_err),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] e_gnt, input logic [5:0] e_en,
                           input logic [7:0] e_data, input logic e_busy, input logic e_err);
    check({tag, ".gnt"},      32'(gnt),        32'(e_gnt));
    check({tag, ".enable"},   32'(reg_enable), 32'(e_en));
    check({tag, ".data"},     32'(reg_data),   32'(e_data));
    check({tag, ".busy"},     32'(busy),       32'(e_busy));
    check({tag, ".addr_err"}, 32'(addr_err),   32'(e_err));
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b111;
    a0 = 3'd0; a1 = 3'd1; a2 = 3'd2;
    d0 = 8'd11; d1 = 8'd22; d2 = 8'd33;

    // Reset held with all requests active.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("reset", 3'b000, 6'b000000, 8'h00, 1'b0, 1'b0);
    end

    // Release: round-robin from pointer 0.
    rst = 1'b0;
    tick(); check_out("rr0", 3'b001, 6'b000001, 8'd11, 1'b1, 1'b0);
    tick(); check_out("rr1", 3'b010, 6'b000010, 8'd22, 1'b1, 1'b0);
    tick(); check_out("rr2", 3'b100, 6'b000100, 8'd33, 1'b1, 1'b0);
    tick(); check_out("rr3", 3'b001, 6'b000001, 8'd11, 1'b1, 1'b0);
    req = 3'b000;
    tick(); check_out("rr_idle", 3'b000, 6'b000000, 8'h00, 1'b0, 1'b0);

    // Single write from LOAD (pointer now 1).
    req = 3'b010; a1 = 3'd5; d1 = 8'hA5;
    tick(); check_out("single", 3'b010, 6'b100000, 8'hA5, 1'b1, 1'b0);
    req = 3'b000;
    tick(); check_out("single_idle", 3'b000, 6'b000000, 8'h00, 1'b0, 1'b0);

    // Held ALU request: grant every other cycle.
    req = 3'b001; a0 = 3'd3; d0 = 8'h0F;
    tick(); check_out("b2b0", 3'b001, 6'b001000, 8'h0F, 1'b1, 1'b0);
    tick(); check_out("b2b1", 3'b000, 6'b000000, 8'h00, 1'b0, 1'b0);
    tick(); check_out("b2b2", 3'b001, 6'b001000, 8'h0F, 1'b1, 1'b0);
    tick(); check_out("b2b3", 3'b000, 6'b000000, 8'h00, 1'b0, 1'b0);
    req = 3'b000;
    tick();

    // Out-of-range addresses 7 and 6, then in-range boundary 5, all from IMM.
    req = 3'b100; a2 = 3'd7; d2 = 8'h5A;
    tick();
    check("bad7.gnt",    32'(gnt),        32'(3'b100));
    check("bad7.enable", 32'(reg_enable), 32'(6'b000000));
    check("bad7.err",    32'(addr_err),   32'(1'b1));
    check("bad7.busy",   32'(busy),       32'(1'b1));
    req = 3'b000;
    tick(); check_out("bad7_idle", 3'b000, 6'b000000, 8'h00, 1'b0, 1'b0);
    req = 3'b100; a2 = 3'd6;
    tick();
    check("bad6.gnt",    32'(gnt),        32'(3'b100));
    check("bad6.enable", 32'(reg_enable), 32'(6'b000000));
    check("bad6.err",    32'(addr_err),   32'(1'b1));
    req = 3'b000;
    tick();
    req = 3'b100; a2 = 3'd5; d2 = 8'h77;
    tick(); check_out("edge5", 3'b100, 6'b100000, 8'h77, 1'b1, 1'b0);
    req = 3'b000;
    tick();

    // Reset while ALU's write is showing; LOAD still pending.
    req = 3'b011; a0 = 3'd1; d0 = 8'hC1; a1 = 3'd4; d1 = 8'hC4;
    tick(); check_out("mid_pre", 3'b001, 6'b000010, 8'hC1, 1'b1, 1'b0);
    rst = 1'b1;
    tick(); check_out("mid_rst", 3'b000, 6'b000000, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); check_out("mid_post0", 3'b001, 6'b000010, 8'hC1, 1'b1, 1'b0);
    tick(); check_out("mid_post1", 3'b010, 6'b010000, 8'hC4, 1'b1, 1'b0);
    req = 3'b000;
    tick(); check_out("final_idle", 3'b000, 6'b000000, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
